// File: rtl/sdc_cmd_issuer_pkg.sv
// rtl/sdc_cmd_issuer_pkg.sv - shared encodings, timing constants and helpers for the SD command issuer
package sdc_cmd_issuer_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_R1   = 2'd1,
    RESP_R2   = 2'd2,
    RESP_R3   = 2'd3
  } resp_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUILD,
    ST_SEND,
    ST_WAIT_RESP,
    ST_CHK_IDX,
    ST_CHK_CRC,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [7:0] RESP_TO      = 8'd128;
  localparam logic [7:0] NO_RESP_WAIT = 8'd56;
  localparam logic [7:0] CRC_WIN_R1   = 8'd48;
  localparam logic [7:0] CRC_WIN_R2   = 8'd136;
  localparam logic [3:0] RETRY_GAP    = 4'd8;
  localparam logic [1:0] MAX_RETRY    = 2'd2;

  localparam logic [1:0] START_BITS = 2'b01;
  localparam logic       END_BIT    = 1'b1;
  localparam logic [7:0] HDR_BITS   = 8'd40;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sdc_cmd_issuer_if.sv
// rtl/sdc_cmd_issuer_if.sv - request, response-supervision and status signals of the command issuer
interface sdc_cmd_issuer_if;
  logic        cmd_req_strb;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [1:0]  resp_type;
  logic        new_response_packet_strb;
  logic        new_response_2_packet_strb;
  logic        r1_crc7_good_out;
  logic        r2_crc7_good_out;
  logic        cmd_indx_err;
  logic        snd_cmd_strb;
  logic [47:0] cmd_packet;
  logic        r2_resp_enb;
  logic        busy;
  logic        done_strb;
  logic        timeout_err;
  logic        crc_err;
  logic        indx_err;
  logic [1:0]  retry_cnt;

  modport slave (
    input  cmd_req_strb, cmd_index, cmd_arg, resp_type,
    input  new_response_packet_strb, new_response_2_packet_strb,
    input  r1_crc7_good_out, r2_crc7_good_out, cmd_indx_err,
    output snd_cmd_strb, cmd_packet, r2_resp_enb, busy, done_strb,
    output timeout_err, crc_err, indx_err, retry_cnt
  );

  modport master (
    output cmd_req_strb, cmd_index, cmd_arg, resp_type,
    output new_response_packet_strb, new_response_2_packet_strb,
    output r1_crc7_good_out, r2_crc7_good_out, cmd_indx_err,
    input  snd_cmd_strb, cmd_packet, r2_resp_enb, busy, done_strb,
    input  timeout_err, crc_err, indx_err, retry_cnt
  );
endinterface

// File: rtl/sd_crc_7.sv
// rtl/sd_crc_7.sv - serial CRC7 (x^7 + x^3 + 1), one bit per enabled clock, synchronous clear
module sd_crc_7 (
  input  logic       BITVAL,
  input  logic       Enable,
  input  logic       CLK,
  input  logic       RST,
  output logic [6:0] CRC
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic       inv;

  assign inv = BITVAL ^ crc_q[6];

  always_comb begin
    crc_d = crc_q;
    if (RST) begin
      crc_d = '0;
    end else if (Enable) begin
      crc_d = {crc_q[5:3], crc_q[2] ^ inv, crc_q[1:0], inv};
    end
  end

  always_ff @(posedge CLK) begin
    crc_q <= crc_d;
  end

  assign CRC = crc_q;

endmodule

// File: rtl/sdc_cmd_issuer.sv
// rtl/sdc_cmd_issuer.sv - builds a CRC7-protected SD command, strobes the send stage,
// supervises the response and retries on timeout or CRC failure.
module sdc_cmd_issuer
  import sdc_cmd_issuer_pkg::*;
(
  input  logic              sd_clk,
  input  logic              reset,
  sdc_cmd_issuer_if.slave   bus
);

  state_e      state_q, state_d;
  resp_type_e  type_q, type_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  gap_q, gap_d;
  logic [1:0]  retry_cnt_q, retry_cnt_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [47:0] packet_q, packet_d;
  logic        snd_q, snd_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        r2_q, r2_d;
  logic        to_q, to_d;
  logic        crc_err_q, crc_err_d;
  logic        indx_q, indx_d;

  logic [39:0] header;
  logic [5:0]  bit_idx;
  logic        crc_bit;
  logic        crc_en;
  logic        crc_clr;
  logic [6:0]  crc7;
  logic        attempt_failed;
  logic        crc_good;
  logic [7:0]  crc_win;

  assign header  = {START_BITS, idx_q, arg_q};
  assign bit_idx = 6'd39 - cnt_q[5:0];
  assign crc_en  = (state_q == ST_BUILD) && (cnt_q < HDR_BITS);
  assign crc_bit = crc_en ? header[bit_idx] : 1'b0;
  // Holding the CRC cleared through IDLE guarantees a clean start on BUILD entry.
  assign crc_clr = (state_q == ST_IDLE);

  sd_crc_7 u_crc (
    .BITVAL (crc_bit),
    .Enable (crc_en),
    .CLK    (sd_clk),
    .RST    (crc_clr),
    .CRC    (crc7)
  );

  assign crc_good = (type_q == RESP_R2) ? bus.r2_crc7_good_out : bus.r1_crc7_good_out;
  assign crc_win  = (type_q == RESP_R2) ? CRC_WIN_R2 : CRC_WIN_R1;

  always_comb begin
    state_d        = state_q;
    type_d         = type_q;
    cnt_d          = cnt_q;
    gap_d          = gap_q;
    retry_cnt_d    = retry_cnt_q;
    idx_d          = idx_q;
    arg_d          = arg_q;
    packet_d       = packet_q;
    r2_d           = r2_q;
    to_d           = to_q;
    crc_err_d      = crc_err_q;
    indx_d         = indx_q;
    attempt_failed = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_req_strb) begin
          idx_d       = bus.cmd_index;
          arg_d       = bus.cmd_arg;
          type_d      = resp_type_e'(bus.resp_type);
          r2_d        = (bus.resp_type == RESP_R2);
          to_d        = 1'b0;
          crc_err_d   = 1'b0;
          indx_d      = 1'b0;
          retry_cnt_d = '0;
          cnt_d       = '0;
          state_d     = ST_BUILD;
        end
      end
      ST_BUILD: begin
        if (cnt_q == HDR_BITS) begin
          packet_d = {header, crc7, END_BIT};
          cnt_d    = '0;
          state_d  = ST_SEND;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SEND: begin
        cnt_d   = sat_inc8(cnt_q);
        state_d = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        // A response landing on the final timeout cycle still wins.
        if ((type_q == RESP_R1 || type_q == RESP_R3) && bus.new_response_packet_strb) begin
          state_d = ST_CHK_IDX;
        end else if (type_q == RESP_R2 && bus.new_response_2_packet_strb) begin
          cnt_d   = '0;
          state_d = ST_CHK_CRC;
        end else if (type_q == RESP_NONE && cnt_q == NO_RESP_WAIT - 8'd1) begin
          state_d = ST_DONE;
        end else if (type_q != RESP_NONE && cnt_q == RESP_TO - 8'd1) begin
          to_d           = 1'b1;
          attempt_failed = 1'b1;
        end else begin
          cnt_d = sat_inc8(cnt_q);
        end
      end
      ST_CHK_IDX: begin
        if (type_q == RESP_R3) begin
          state_d = ST_DONE;
        end else if (bus.cmd_indx_err) begin
          indx_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d   = '0;
          state_d = ST_CHK_CRC;
        end
      end
      ST_CHK_CRC: begin
        if (crc_good) begin
          state_d = ST_DONE;
        end else if (cnt_q == crc_win - 8'd1) begin
          crc_err_d      = 1'b1;
          attempt_failed = 1'b1;
        end else begin
          cnt_d = sat_inc8(cnt_q);
        end
      end
      ST_GAP: begin
        if (gap_q == RETRY_GAP - 4'd1) begin
          cnt_d   = '0;
          state_d = ST_SEND;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Retries resend the already-built packet; the last failure keeps its flag.
    if (attempt_failed) begin
      if (retry_cnt_q < MAX_RETRY) begin
        retry_cnt_d = retry_cnt_q + 2'd1;
        to_d        = 1'b0;
        crc_err_d   = 1'b0;
        gap_d       = '0;
        state_d     = ST_GAP;
      end else begin
        state_d = ST_DONE;
      end
    end

    snd_d  = (state_d == ST_SEND);
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_IDLE) begin
      r2_d = 1'b0;
    end
  end

  always_ff @(posedge sd_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      type_q      <= RESP_NONE;
      cnt_q       <= '0;
      gap_q       <= '0;
      retry_cnt_q <= '0;
      idx_q       <= '0;
      arg_q       <= '0;
      packet_q    <= {47'd0, END_BIT};
      snd_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      r2_q        <= 1'b0;
      to_q        <= 1'b0;
      crc_err_q   <= 1'b0;
      indx_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      retry_cnt_q <= retry_cnt_d;
      idx_q       <= idx_d;
      arg_q       <= arg_d;
      packet_q    <= packet_d;
      snd_q       <= snd_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      r2_q        <= r2_d;
      to_q        <= to_d;
      crc_err_q   <= crc_err_d;
      indx_q      <= indx_d;
    end
  end

  assign bus.snd_cmd_strb = snd_q;
  assign bus.cmd_packet   = packet_q;
  assign bus.r2_resp_enb  = r2_q;
  assign bus.busy         = busy_q;
  assign bus.done_strb    = done_q;
  assign bus.timeout_err  = to_q;
  assign bus.crc_err      = crc_err_q;
  assign bus.indx_err     = indx_q;
  assign bus.retry_cnt    = retry_cnt_q;

endmodule

// File: tb/tb_sdc_cmd_issuer.sv
// tb/tb_sdc_cmd_issuer.sv - scoreboard bench: directed commands queue expected sends/completions,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_sdc_cmd_issuer;

  logic sd_clk = 1'b0;
  logic reset  = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   passed = 0;

  always #5 sd_clk = ~sd_clk;
  always @(posedge sd_clk) cyc <= cyc + 1;

  sdc_cmd_issuer_if bus ();

  sdc_cmd_issuer dut (
    .sd_clk (sd_clk),
    .reset  (reset),
    .bus    (bus)
  );

  typedef struct {
    int          cyc;
    logic [47:0] pkt;
    logic        r2;
  } snd_t;

  typedef struct {
    int          cyc;
    logic [4:0]  st;
    logic        r2;
  } done_t;

  snd_t  exp_snd[$];
  done_t exp_done[$];
  snd_t  es;
  done_t ed;

  localparam int P_R48 = 0, P_R136 = 1, P_R1G = 2, P_R2G = 3, P_IDX = 4, P_REQ = 5;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_snd(input int c, input logic [47:0] p, input logic r2);
    exp_snd.push_back('{c, p, r2});
  endtask

  task automatic push_done(input int c, input logic [4:0] st, input logic r2);
    exp_done.push_back('{c, st, r2});
  endtask

  task automatic wait_neg(input int c);
    while (cyc < c) @(negedge sd_clk);
  endtask

  // Drives a one-cycle pulse so that the DUT samples it on posedge number edge_n.
  task automatic pulse(input int edge_n, input int which);
    wait_neg(edge_n - 1);
    case (which)
      P_R48:   bus.new_response_packet_strb   = 1'b1;
      P_R136:  bus.new_response_2_packet_strb = 1'b1;
      P_R1G:   bus.r1_crc7_good_out           = 1'b1;
      P_R2G:   bus.r2_crc7_good_out           = 1'b1;
      P_IDX:   bus.cmd_indx_err               = 1'b1;
      default: begin bus.cmd_req_strb = 1'b1; bus.cmd_index = 6'd55; end
    endcase
    @(negedge sd_clk);
    bus.new_response_packet_strb   = 1'b0;
    bus.new_response_2_packet_strb = 1'b0;
    bus.r1_crc7_good_out           = 1'b0;
    bus.r2_crc7_good_out           = 1'b0;
    bus.cmd_indx_err               = 1'b0;
    bus.cmd_req_strb               = 1'b0;
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] ty,
                       output int t);
    @(negedge sd_clk);
    bus.cmd_index    = idx;
    bus.cmd_arg      = arg;
    bus.resp_type    = ty;
    bus.cmd_req_strb = 1'b1;
    t = cyc + 1;
    @(negedge sd_clk);
    bus.cmd_req_strb = 1'b0;
  endtask

  always @(negedge sd_clk) begin
    if (bus.snd_cmd_strb) begin
      if (exp_snd.size() == 0) begin
        checks++;
        $display("FAIL unexpected_snd: send strobe at cycle %0d, none expected", cyc);
      end else begin
        es = exp_snd.pop_front();
        chk("snd_cycle", 64'(cyc), 64'(es.cyc));
        chk("snd_packet", 64'(bus.cmd_packet), 64'(es.pkt));
        chk("snd_r2_enb", 64'(bus.r2_resp_enb), 64'(es.r2));
      end
    end
    if (bus.done_strb) begin
      if (exp_done.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: done strobe at cycle %0d, none expected", cyc);
      end else begin
        ed = exp_done.pop_front();
        chk("done_cycle", 64'(cyc), 64'(ed.cyc));
        chk("done_status{to,crc,idx,retry}",
            64'({bus.timeout_err, bus.crc_err, bus.indx_err, bus.retry_cnt}), 64'(ed.st));
        chk("done_r2_enb", 64'(bus.r2_resp_enb), 64'(ed.r2));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    int s;
    int s2;
    bus.cmd_req_strb               = 1'b0;
    bus.cmd_index                  = '0;
    bus.cmd_arg                    = '0;
    bus.resp_type                  = '0;
    bus.new_response_packet_strb   = 1'b0;
    bus.new_response_2_packet_strb = 1'b0;
    bus.r1_crc7_good_out           = 1'b0;
    bus.r2_crc7_good_out           = 1'b0;
    bus.cmd_indx_err               = 1'b0;

    repeat (3) @(negedge sd_clk);
    reset = 1'b1;
    @(negedge sd_clk);
    chk("rst_packet", 64'(bus.cmd_packet), 64'h0000_0000_0001);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_strobes", 64'({bus.snd_cmd_strb, bus.done_strb}), 64'd0);
    chk("rst_status", 64'({bus.timeout_err, bus.crc_err, bus.indx_err, bus.retry_cnt}), 64'd0);
    chk("rst_r2_enb", 64'(bus.r2_resp_enb), 64'd0);

    // CMD0, no response
    issue(6'd0, 32'h0, 2'd0, t);
    s = t + 41;
    push_snd(s, 48'h40_0000_0000_95, 1'b0);
    push_done(s + 56, 5'b00000, 1'b0);
    wait_neg(s + 56);
    chk("busy_in_done", 64'(bus.busy), 64'd1);
    wait_neg(s + 57);
    chk("busy_after_done", 64'(bus.busy), 64'd0);
    chk("packet_held", 64'(bus.cmd_packet), 64'h40_0000_0000_95);

    // CMD8 R1, good; a request while busy is ignored
    issue(6'd8, 32'h1AA, 2'd1, t);
    s = t + 41;
    push_snd(s, 48'h48_0000_01AA_87, 1'b0);
    push_done(s + 104, 5'b00000, 1'b0);
    pulse(s + 10, P_REQ);
    pulse(s + 60, P_R48);
    pulse(s + 104, P_R1G);
    wait_neg(s + 110);

    // CMD55 R1, never answered: three sends then timeout
    issue(6'd55, 32'h0, 2'd1, t);
    s = t + 41;
    push_snd(s, 48'h77_0000_0000_65, 1'b0);
    push_snd(s + 136, 48'h77_0000_0000_65, 1'b0);
    push_snd(s + 272, 48'h77_0000_0000_65, 1'b0);
    push_done(s + 400, 5'b10010, 1'b0);
    wait_neg(s + 405);

    // CMD17 R1: CRC window expires, resend answered exactly on the timeout cycle
    issue(6'd17, 32'h0, 2'd1, t);
    s  = t + 41;
    s2 = s + 117;
    push_snd(s, 48'h51_0000_0000_55, 1'b0);
    push_snd(s2, 48'h51_0000_0000_55, 1'b0);
    push_done(s2 + 137, 5'b00001, 1'b0);
    pulse(s + 60, P_R48);
    pulse(s2 + 127, P_R48);
    pulse(s2 + 137, P_R1G);
    wait_neg(s2 + 140);

    // CMD58 R1 with index error: flagged, no resend
    issue(6'd58, 32'h0, 2'd1, t);
    s = t + 41;
    push_snd(s, 48'h7A_0000_0000_FD, 1'b0);
    push_done(s + 61, 5'b00100, 1'b0);
    pulse(s + 60, P_R48);
    pulse(s + 61, P_IDX);
    wait_neg(s + 200);

    // CMD58 R3, same stimulus: no check, no error
    issue(6'd58, 32'h0, 2'd3, t);
    s = t + 41;
    push_snd(s, 48'h7A_0000_0000_FD, 1'b0);
    push_done(s + 61, 5'b00000, 1'b0);
    pulse(s + 60, P_R48);
    pulse(s + 61, P_IDX);
    wait_neg(s + 200);

    // CMD2 R2: 48-bit strobe ignored, R2 strobe then good pulse
    issue(6'd2, 32'h0, 2'd2, t);
    s = t + 41;
    push_snd(s, 48'h42_0000_0000_4D, 1'b1);
    push_done(s + 200, 5'b00000, 1'b1);
    pulse(s + 40, P_R48);
    pulse(s + 70, P_R136);
    wait_neg(s + 100);
    chk("r2_enb_mid", 64'(bus.r2_resp_enb), 64'd1);
    pulse(s + 200, P_R2G);
    wait_neg(s + 205);

    // Reset during WAIT_RESP aborts silently
    issue(6'd0, 32'h0, 2'd1, t);
    s = t + 41;
    push_snd(s, 48'h40_0000_0000_95, 1'b0);
    wait_neg(s + 20);
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_packet", 64'(bus.cmd_packet), 64'h0000_0000_0001);
    @(negedge sd_clk);
    reset = 1'b1;
    wait_neg(s + 300);

    // Recovery after abort
    issue(6'd0, 32'h0, 2'd0, t);
    s = t + 41;
    push_snd(s, 48'h40_0000_0000_95, 1'b0);
    push_done(s + 56, 5'b00000, 1'b0);
    wait_neg(s + 60);

    chk("snd_queue_drained", 64'(exp_snd.size()), 64'd0);
    chk("done_queue_drained", 64'(exp_done.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sdc_cmd_issuer.md
Name: sdc_cmd_issuer

Overview:
Command-issue sequencer that sits directly upstream of the SD command send/receive stage.
- Takes a command request (index, argument, response type) from the host-side controller.
- Builds the 48-bit command packet, computing its CRC7 serially, then strobes the send stage.
- Supervises the returned response: timeout, CRC7 result, command-index error.
- Retries on failure and reports one completion strobe with status to the controller.

Parameters:
RESP_TO, 8'd128, sd_clk cycles from snd_cmd_strb to response strobe before a timeout is declared
NO_RESP_WAIT, 8'd56, cycles after snd_cmd_strb before a no-response command completes (48 tx + 8 Ncc)
CRC_WIN_R1, 8'd48, cycles after a 48-bit response strobe allowed for r1_crc7_good_out
CRC_WIN_R2, 8'd136, cycles after a 136-bit response strobe allowed for r2_crc7_good_out
RETRY_GAP, 4'd8, idle cycles between a failed attempt and its resend
MAX_RETRY, 2'd2, resends after the first attempt

Ports:
sd_clk  in  1  SD clock; the only clock
reset  in  1  asynchronous, active-low reset
cmd_req_strb  in  1  one-cycle request; accepted only in IDLE
cmd_index  in  6  command index; captured on an accepted request
cmd_arg  in  32  argument; captured on an accepted request
resp_type  in  2  0 = none, 1 = 48-bit with CRC (R1/R6/R7), 2 = R2 (136-bit), 3 = R3 (48-bit, no CRC/index check)
new_response_packet_strb  in  1  48-bit response received, from the send/receive stage
new_response_2_packet_strb  in  1  136-bit response received
r1_crc7_good_out  in  1  one-cycle pulse when the R1 CRC matches
r2_crc7_good_out  in  1  one-cycle pulse when the R2 CRC matches
cmd_indx_err  in  1  pulse one cycle after new_response_packet_strb on index mismatch
snd_cmd_strb  out  1  one-cycle send strobe to the send/receive stage
cmd_packet  out  48  {0,1,index,arg,crc7,1}
r2_resp_enb  out  1  high while the active command is resp_type 2
busy  out  1  high in every state except IDLE
done_strb  out  1  one-cycle completion pulse
timeout_err  out  1  status, valid from done_strb until the next accepted request
crc_err  out  1  status, same validity
indx_err  out  1  status, same validity
retry_cnt  out  2  number of resends used

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - cmd_packet = 48'h0000_0000_0001; all other outputs 0.
  - Reset mid-operation aborts the command; no done_strb is produced.
- States: IDLE, BUILD, SEND, WAIT_RESP, CHK_IDX, CHK_CRC, GAP, DONE.
- IDLE:
  - On cmd_req_strb, latch index/arg/type, clear status and retry_cnt, go to BUILD.
  - A request while busy is ignored.
- BUILD (40 cycles):
  - Shift the 40 header bits {0,1,index,arg} MSB-first, one per cycle, through sd_crc_7 (cleared on entry).
  - On the 40th cycle, load cmd_packet[7:1] = CRC and bit 0 = 1.
  - Latency: request sampled at edge T, snd_cmd_strb high at cycle T+41.
  - cmd_packet stays stable from SEND until the next accepted request.
- SEND: snd_cmd_strb = 1 for exactly one cycle. Start the 8-bit wait counter at 0. Go to WAIT_RESP.
- WAIT_RESP:
  - Type 0: at counter = NO_RESP_WAIT-1, go to DONE with no error.
  - Types 1/3: new_response_packet_strb goes to CHK_IDX.
  - Type 2: new_response_2_packet_strb goes to CHK_CRC.
  - A strobe of the other width is ignored.
  - Counter reaching RESP_TO-1 with no strobe: set timeout_err, go to the retry decision.
  - A strobe arriving in the same cycle as the counter reaching RESP_TO-1 is a response, not a timeout.
- CHK_IDX (1 cycle): sample cmd_indx_err.
  - Type 3 skips the check and goes to DONE.
  - Type 1: error sets indx_err and goes to DONE (no retry). Otherwise go to CHK_CRC.
- CHK_CRC:
  - Counter restarts at 0.
  - The matching good pulse within CRC_WIN_R1 (type 1) or CRC_WIN_R2 (type 2) cycles goes to DONE.
  - Window expiry sets crc_err and goes to the retry decision.
- Retry decision:
  - If retry_cnt < MAX_RETRY: increment retry_cnt, clear timeout_err/crc_err, go to GAP.
  - GAP lasts RETRY_GAP cycles, then SEND with the same cmd_packet; no rebuild.
  - Otherwise go to DONE with the error flag kept.
- DONE (1 cycle): done_strb = 1, busy = 0 on the following cycle, return to IDLE.
- Counters saturate; they never wrap.

Decomposition:
- Shared package holds:
  - resp_type encodings (RESP_NONE, RESP_R1, RESP_R2, RESP_R3);
  - state encodings;
  - packet constants: START_BITS = 2'b01, END_BIT = 1'b1.
- Reuse the existing sd_crc_7 as the single sub-module (BITVAL/Enable/CLK/RST).

Test Plan:
- CMD0, arg 0, type 0 → cmd_packet = 48'h40_0000_0000_95; snd_cmd_strb at T+41; done_strb 56 cycles later; all errors 0.
- CMD8, arg 32'h1AA, type 1; response strobe at +60, good pulse at +44 after it → cmd_packet = 48'h48_0000_01AA_87; done_strb with no errors; retry_cnt 0.
- Type 1, no response ever → 3 sends spaced 128+8 cycles apart; done_strb with timeout_err = 1, retry_cnt = 2.
- Type 1, response but no good pulse; second attempt good → crc_err = 0 at done; retry_cnt = 1.
- Type 1, cmd_indx_err pulsed → indx_err = 1; no resend. Type 3 with the same stimulus → no error.
- Type 2: R2 strobe at +70, good pulse at +130 → done, no error, r2_resp_enb high throughout. Also: reset asserted during WAIT_RESP clears busy immediately and no done_strb follows.
